conv_batch_sequencer: RTL
=========================

Name: conv_batch_sequencer

Overview:
- Controller that sequences the integer-to-float conversion engine across a batch of operands held in byte-wide data memory.
- Per operand: fetch the 16-bit integer (two bytes), launch the engine with a start/done handshake, write the 16-bit float result (two bytes) back to memory.
- Sits between the top-level go/done control and the shared data memory plus conversion datapath; it is the only memory master while busy.

Parameters:
- AW, 8, data-memory address width; all address arithmetic is modulo 2**AW.
- CW, 6, width of batch count and progress counter.
- TIMEOUT, 255, max cycles spent in WAIT for eng_done before aborting.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle batch launch; sampled in IDLE only.
- src_base  in  AW  byte address of operand 0 low byte; sampled on go.
- dst_base  in  AW  byte address of result 0 low byte; sampled on go.
- count  in  CW  number of operands; sampled on go.
- busy  out  1  high from the cycle after an accepted go until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag; cleared by next accepted go.
- processed  out  CW  operands fully written back in current/last batch.
- mem_addr  out  AW  memory address.
- mem_rd_en  out  1  read strobe; data returns on mem_rdata next cycle.
- mem_rdata  in  8  read data (1-cycle synchronous latency).
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  8  write data.
- eng_start  out  1  engine start request.
- eng_operand  out  16  integer presented to engine.
- eng_done  in  1  engine completion (level or pulse).
- eng_result  in  16  engine float result; valid while eng_done high.

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, err, mem_rd_en, mem_wr_en, eng_start = 0; processed, mem_addr, mem_wdata, eng_operand = 0. A reset mid-batch abandons the operation; no further memory writes occur.
- Byte order: low byte at the lower address, high byte at address+1, for both operands and results.
- Addresses: operand i at src_base+2i and src_base+2i+1; result i at dst_base+2i and dst_base+2i+1; all wrap modulo 2**AW.
- IDLE:
  - go=1, count≠0: latch inputs, clear processed and err, go to RD_LO.
  - go=1, count=0: clear err, pulse done next cycle; busy stays 0; no memory or engine activity.
- RD_LO: mem_addr=src+2i, mem_rd_en=1.
- RD_HI: mem_addr=src+2i+1, mem_rd_en=1; capture mem_rdata into eng_operand[7:0].
- CAPT: capture mem_rdata into eng_operand[15:8].
- START: eng_start=1 for exactly 2 consecutive cycles; eng_operand is stable from CAPT until leaving WAIT.
- WAIT:
  - eng_done is ignored during START and sampled from the first WAIT cycle.
  - On eng_done=1: latch eng_result, go to WR_LO.
  - Wait counter increments each WAIT cycle; after TIMEOUT cycles with no eng_done, go to FIN with err=1.
- WR_LO: mem_addr=dst+2i, mem_wdata=result[7:0], mem_wr_en=1.
- WR_HI: mem_addr=dst+2i+1, mem_wdata=result[15:8], mem_wr_en=1; processed increments.
- NEXT: if processed==count go to FIN, else i+1 and go to RD_LO.
- FIN: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- go while busy is ignored; no queuing.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Per-operand latency: 3 + 2 + W + 2 + 1 cycles, where W is the number of WAIT cycles.

Test Plan:
- Single operand: mem[0]=0x01, mem[1]=0x00, src_base=0, dst_base=2, count=1, engine returns 0x3C00 → eng_operand=0x0001, mem[2]=0x00, mem[3]=0x3C, processed=1, one done pulse, err=0.
- Batch of 3: operands 0x0002, 0x000C, 0x8F00 at 0x10..0x15, dst_base=0x20 → three start/done handshakes in order; results written at 0x20..0x25; processed=3.
- count=0 → done pulse on the cycle after go; no mem_rd_en, mem_wr_en or eng_start ever asserted.
- Wrap: src_base=0xFE, count=2 → reads at FE, FF, 00, 01; dst_base=0xFF → writes at FF, 00, 01, 02.
- Timeout: engine never asserts eng_done, TIMEOUT=255 → done after 255 WAIT cycles, err=1, processed=0, no writes; the next go clears err.
- Reset low during WAIT of operand 2 → all outputs 0 immediately; no result-2 write; a subsequent go restarts cleanly.

Source files
------------

// File: rtl/conv_batch_sequencer_if.sv
// Signal bundle between the conversion batch sequencer and its surroundings:
// top-level go/done control, the shared byte-wide data memory and the
// integer-to-float conversion engine.
interface conv_batch_sequencer_if #(
  parameter int AW = 8,
  parameter int CW = 6
);
  // top-level control
  logic          go;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] processed;

  // data memory
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_rdata;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;

  // conversion engine
  logic          eng_start;
  logic [15:0]   eng_operand;
  logic          eng_done;
  logic [15:0]   eng_result;

  // sequencer side
  modport master (
    input  go, src_base, dst_base, count,
    input  mem_rdata, eng_done, eng_result,
    output busy, done, err, processed,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output eng_start, eng_operand
  );

  // controller / memory / engine side
  modport slave (
    output go, src_base, dst_base, count,
    output mem_rdata, eng_done, eng_result,
    input  busy, done, err, processed,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  eng_start, eng_operand
  );
endinterface

// File: rtl/conv_batch_sequencer.sv
// Batch sequencer for the integer-to-float conversion engine. Walks an array
// of 16-bit integers in byte-wide memory, hands each one to the engine with a
// start/done handshake and writes the 16-bit float result back. It is the only
// memory master while busy.
module conv_batch_sequencer #(
  parameter int AW      = 8,
  parameter int CW      = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  conv_batch_sequencer_if.master bus
);

  // state      | meaning
  // -----------+------------------------------------------------------------
  // S_IDLE     | waiting for go; inputs sampled here only
  // S_RD_LO    | read request for operand low byte
  // S_RD_HI    | read request for operand high byte, capture low byte
  // S_CAPT     | capture operand high byte
  // S_START_A  | first eng_start cycle (eng_done ignored)
  // S_START_B  | second eng_start cycle (eng_done ignored), arm wait counter
  // S_WAIT     | wait for eng_done, bounded by TIMEOUT cycles
  // S_WR_LO    | write result low byte
  // S_WR_HI    | write result high byte, bump processed
  // S_NEXT     | batch complete check / advance to next operand
  // S_FIN      | one-cycle done pulse, busy already low
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_LO   = 4'd1,
    S_RD_HI   = 4'd2,
    S_CAPT    = 4'd3,
    S_START_A = 4'd4,
    S_START_B = 4'd5,
    S_WAIT    = 4'd6,
    S_WR_LO   = 4'd7,
    S_WR_HI   = 4'd8,
    S_NEXT    = 4'd9,
    S_FIN     = 4'd10
  } state_t;

  // wait counter only needs to reach TIMEOUT-1; the TIMEOUT-th cycle exits
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] processed_q, processed_d;
  logic          err_q, err_d;
  logic [15:0]   operand_q, operand_d;
  logic [15:0]   result_q, result_d;
  logic [TW-1:0] wcnt_q, wcnt_d;

  // processed doubles as the operand index: it only advances after the
  // result of the current operand has been fully written
  logic [AW-1:0] byte_off;
  logic [AW-1:0] rd_addr_lo, rd_addr_hi;
  logic [AW-1:0] wr_addr_lo, wr_addr_hi;
  logic          wait_expired;

  assign byte_off     = AW'({processed_q, 1'b0});
  assign rd_addr_lo   = src_q + byte_off;
  assign rd_addr_hi   = rd_addr_lo + 1'b1;
  assign wr_addr_lo   = dst_q + byte_off;
  assign wr_addr_hi   = wr_addr_lo + 1'b1;
  assign wait_expired = (wcnt_q == WAIT_LAST);

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = (bus.count != '0) ? S_RD_LO : S_FIN;
        end
      end
      S_RD_LO:   state_d = S_RD_HI;
      S_RD_HI:   state_d = S_CAPT;
      S_CAPT:    state_d = S_START_A;
      S_START_A: state_d = S_START_B;
      S_START_B: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done) begin
          state_d = S_WR_LO;
        end else if (wait_expired) begin
          state_d = S_FIN;
        end
      end
      S_WR_LO:   state_d = S_WR_HI;
      S_WR_HI:   state_d = S_NEXT;
      S_NEXT:    state_d = (processed_q == cnt_q) ? S_FIN : S_RD_LO;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // datapath next-state: batch parameters, operand/result capture, counters
  always_comb begin
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    processed_d = processed_q;
    err_d       = err_q;
    operand_d   = operand_q;
    result_d    = result_q;
    wcnt_d      = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          err_d = 1'b0;
          if (bus.count != '0) begin
            src_d       = bus.src_base;
            dst_d       = bus.dst_base;
            cnt_d       = bus.count;
            processed_d = '0;
          end
        end
      end
      S_RD_HI:   operand_d[7:0]  = bus.mem_rdata;
      S_CAPT:    operand_d[15:8] = bus.mem_rdata;
      S_START_B: wcnt_d = '0;
      S_WAIT: begin
        if (bus.eng_done) begin
          result_d = bus.eng_result;
        end else if (wait_expired) begin
          err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WR_HI:   processed_d = processed_q + 1'b1;
      default:   ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      processed_q <= '0;
      err_q       <= 1'b0;
      operand_q   <= '0;
      result_q    <= '0;
      wcnt_q      <= '0;
    end else begin
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      processed_q <= processed_d;
      err_q       <= err_d;
      operand_q   <= operand_d;
      result_q    <= result_d;
      wcnt_q      <= wcnt_d;
    end
  end

  // outputs decoded from state; read and write strobes live in disjoint states
  always_comb begin
    bus.busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    bus.done        = (state_q == S_FIN);
    bus.err         = err_q;
    bus.processed   = processed_q;
    bus.eng_operand = operand_q;
    bus.eng_start   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wdata   = '0;
    case (state_q)
      S_RD_LO: begin
        bus.mem_addr  = rd_addr_lo;
        bus.mem_rd_en = 1'b1;
      end
      S_RD_HI: begin
        bus.mem_addr  = rd_addr_hi;
        bus.mem_rd_en = 1'b1;
      end
      S_START_A,
      S_START_B: bus.eng_start = 1'b1;
      S_WR_LO: begin
        bus.mem_addr  = wr_addr_lo;
        bus.mem_wdata = result_q[7:0];
        bus.mem_wr_en = 1'b1;
      end
      S_WR_HI: begin
        bus.mem_addr  = wr_addr_hi;
        bus.mem_wdata = result_q[15:8];
        bus.mem_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
